dcache_wb: RTL and testbench

- Parametrised write-back, write-allocate data cache with multi-word lines. Successor to the first-generation write-through data cache.
- Sits between the memory stage (ALUResult address, WriteData, funct3) and data_mem.
- Owns all data_mem traffic through a req/ack line-burst interface.
- Asserts stall to the pipeline on a miss until the line is resident.

---
 rtl/dcache_pkg.sv | 56 +++++
 rtl/dcache_wb_if.sv | 12 +
 rtl/dcache_way.sv | 48 ++++
 rtl/dcache_wb.sv | 148 ++++++++++++++
 tb/tb_dcache_wb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and load/store lane helpers for the write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'b0, b};
      F3_HU:   return {16'b0, h};
      F3_W:    return w;
      default: return w;
    endcase
  endfunction

  // Unknown store sizes fall through to a full-word write.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) r[31:16] = d[15:0];
        else        r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Line-burst memory bus between the cache (master) and data_mem (slave).
interface dcache_wb_if #(parameter int DW = 32);
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty per set plus the line data; async read, sync write.
module dcache_way #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 6,
  parameter int WB         = 2,
  parameter int TAG_W      = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [WB-1:0]    rd_word,
  output logic [TAG_W-1:0] tag,
  output logic             valid,
  output logic             dirty,
  output logic [31:0]      rd_data,
  input  logic             data_we,
  input  logic [WB-1:0]    wr_word,
  input  logic [31:0]      wr_data,
  input  logic             meta_we,
  input  logic             meta_dirty,
  input  logic [TAG_W-1:0] meta_tag
);
  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  assign tag     = tag_q[idx];
  assign valid   = valid_q[idx];
  assign dirty   = dirty_q[idx];
  assign rd_data = data_q[idx][rd_word];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= meta_dirty;
    end
  end

  // Tags and data are deliberately left uncleared; valid gates them.
  always_ff @(posedge clk) begin
    if (meta_we) tag_q[idx] <= meta_tag;
    if (data_we) data_q[idx][wr_word] <= wr_data;
  end
endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate data cache; stalls the pipe while a line is written back / refilled.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] ReadData_c,
  output logic                  hit,
  output logic                  stall,
  dcache_wb_if.master           mem
);
  localparam int IDX_W    = $clog2(SETS);
  localparam int WRD_BITS = $clog2(LINE_WORDS);
  localparam int WB       = (LINE_WORDS > 1) ? WRD_BITS : 1;
  localparam int TAG_W    = 32 - 2 - WRD_BITS - IDX_W;

  logic [1:0]       a_off;
  logic [WB-1:0]    a_word;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;

  assign a_off  = addr[1:0];
  assign a_word = (LINE_WORDS > 1) ? addr[2 +: WB] : '0;
  assign a_idx  = addr[2+WRD_BITS +: IDX_W];
  assign a_tag  = addr[32-TAG_W +: TAG_W];

  state_t state, state_nxt;
  logic [WB-1:0]   beat;
  logic            vict, vsel, hit_way, hit_any;
  logic [SETS-1:0] lru;
  logic            req, lookup_hit, miss, last, beat_ack, fill_done;

  logic [WAYS-1:0]             w_valid, w_dirty, w_hit, data_we, meta_we;
  logic [WAYS-1:0][TAG_W-1:0]  w_tag;
  logic [WAYS-1:0][31:0]       w_data;
  logic [WB-1:0]               rd_word;
  logic [31:0]                 wr_data;
  logic                        meta_dirty;

  // A request while reset is held must not look up or stall.
  assign req        = rst_n & (rd_en | wr_en);
  assign hit_any    = |w_hit;
  assign hit_way    = (WAYS > 1) && w_hit[WAYS-1];
  assign lookup_hit = (state == IDLE) & req & hit_any;
  assign miss       = (state == IDLE) & req & ~hit_any;
  assign last       = (beat == WB'(LINE_WORDS - 1));
  assign beat_ack   = (state != IDLE) & mem.mem_ack;
  assign fill_done  = (state == REFILL) & mem.mem_ack & last;

  assign rd_word    = (state == IDLE) ? a_word : beat;
  assign wr_data    = (state == IDLE) ? store_merge(w_data[hit_way], WriteData, a_off, funct3)
                                      : mem.mem_rdata;
  assign meta_dirty = (state == IDLE);

  assign hit        = lookup_hit;
  assign ReadData_c = lookup_hit ? load_extract(w_data[hit_way], a_off, funct3) : '0;

  always_comb begin
    vsel = 1'b0;
    if (!w_valid[0])                         vsel = 1'b0;
    else if (WAYS > 1 && !w_valid[WAYS-1])   vsel = 1'b1;
    else if (WAYS > 1)                       vsel = lru[a_idx];
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit[g]   = w_valid[g] & (w_tag[g] == a_tag);
    assign data_we[g] = (lookup_hit & wr_en & w_hit[g]) |
                        ((state == REFILL) & mem.mem_ack & (vict == 1'(g)));
    assign meta_we[g] = (lookup_hit & wr_en & w_hit[g]) | (fill_done & (vict == 1'(g)));

    dcache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .WB(WB), .TAG_W(TAG_W))
      u_way (
        .clk, .rst_n, .idx(a_idx), .rd_word,
        .tag(w_tag[g]), .valid(w_valid[g]), .dirty(w_dirty[g]), .rd_data(w_data[g]),
        .data_we(data_we[g]), .wr_word(rd_word), .wr_data,
        .meta_we(meta_we[g]), .meta_dirty, .meta_tag(a_tag)
      );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      vict  <= 1'b0;
      lru   <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        vict <= vsel;
        beat <= '0;
      end else if (beat_ack) begin
        beat <= last ? '0 : beat + 1'b1;
      end
      if (lookup_hit)     lru[a_idx] <= ~hit_way;
      else if (fill_done) lru[a_idx] <= ~vict;
    end
  end

  logic        req_c, we_c;
  logic [31:0] maddr_c, wdata_c;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    maddr_c   = '0;
    wdata_c   = '0;
    case (state)
      IDLE: begin
        if (miss) begin
          stall     = 1'b1;
          state_nxt = (w_valid[vsel] & w_dirty[vsel]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall   = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        maddr_c = {w_tag[vict], a_idx, {(WRD_BITS+2){1'b0}}} | (32'(beat) << 2);
        wdata_c = w_data[vict];
        if (mem.mem_ack && last) state_nxt = REFILL;
      end
      REFILL: begin
        stall   = 1'b1;
        req_c   = 1'b1;
        maddr_c = {a_tag, a_idx, {(WRD_BITS+2){1'b0}}} | (32'(beat) << 2);
        if (mem.mem_ack && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = maddr_c;
  assign mem.mem_wdata = wdata_c;
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: beat and load-result scoreboards against a behavioural memory.
module tb_dcache_wb;
  import dcache_pkg::*;

  logic        clk, rst_n, rd_en, wr_en, hit, stall;
  logic [31:0] addr, WriteData, ReadData_c;
  logic [2:0]  funct3;

  dcache_wb_if mif ();

  dcache_wb #(.DATA_WIDTH(32), .SETS(64), .WAYS(2), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .WriteData(WriteData), .funct3(funct3), .ReadData_c(ReadData_c),
    .hit(hit), .stall(stall), .mem(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;

  int          vectors = 0, miscompares = 0;
  int          ack_delay = 1, wcnt = 0, acks = 0;
  beat_t       bq[$];
  logic [31:0] rq[$];
  logic [31:0] mm[logic [31:0]];
  logic [31:0] s_addr, s_wd;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_read(input logic [31:0] base);
    for (int i = 0; i < 4; i++) bq.push_back('{1'b0, base + 32'(4*i), 32'h0});
  endtask

  task automatic exp_write(input logic [31:0] base, input logic [31:0] w0, w1, w2, w3);
    bq.push_back('{1'b1, base,         w0});
    bq.push_back('{1'b1, base + 32'h4, w1});
    bq.push_back('{1'b1, base + 32'h8, w2});
    bq.push_back('{1'b1, base + 32'hC, w3});
  endtask

  // Memory responder: ack arrives ack_delay cycles after a beat starts; checks each beat.
  always @(negedge clk) begin
    beat_t e;
    if (mif.mem_req === 1'b1) begin
      if (wcnt == 0) begin
        s_addr = mif.mem_addr;
        s_wd   = mif.mem_wdata;
      end else begin
        chk("hold_addr",  mif.mem_addr,  s_addr);
        chk("hold_wdata", mif.mem_wdata, s_wd);
        chk("hold_stall", 32'(stall),    32'd1);
      end
      if (wcnt == ack_delay) begin
        mif.mem_ack = 1'b1;
        wcnt = 0;
        acks++;
        vectors++;
        assert (bq.size() != 0) else begin
          miscompares++;
          $error("FAIL beat_unexpected observed=%h expected=none", mif.mem_addr);
        end
        if (bq.size() != 0) begin
          e = bq.pop_front();
          chk("beat_we",   32'(mif.mem_we), 32'(e.we));
          chk("beat_addr", mif.mem_addr,    e.addr);
          if (e.we) chk("beat_wdata", mif.mem_wdata, e.data);
        end
        if (mif.mem_we) mm[mif.mem_addr] = mif.mem_wdata;
        else mif.mem_rdata = mm.exists(mif.mem_addr) ? mm[mif.mem_addr] : 32'h0;
      end else begin
        mif.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mif.mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3, input logic [31:0] exp,
                        input int exp_stall);
    int          n;
    bit          done, bad;
    logic [31:0] e;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; addr = a; WriteData = d; funct3 = f3;
    if (!wr) rq.push_back(exp);
    n = 0; done = 0; bad = 0;
    while (!done && !bad && n < 200) begin
      @(negedge clk);
      if (hit) done = 1;
      else if (!stall) bad = 1;
      else n++;
    end
    chk({tag, "_hit"},          32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(n),    32'(exp_stall));
    if (done) begin
      chk({tag, "_stall_drop"}, 32'(stall),       32'd0);
      chk({tag, "_no_mem_req"}, 32'(mif.mem_req), 32'd0);
      chk({tag, "_beats_left"}, 32'(bq.size()),   32'd0);
    end
    if (!wr) begin
      e = rq.pop_front();
      if (done) chk({tag, "_data"}, ReadData_c, e);
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, start;
    rst_n = 0; rd_en = 0; wr_en = 0; addr = 0; WriteData = 0; funct3 = F3_W;
    mif.mem_ack = 0; mif.mem_rdata = 0;
    foreach (bq[i]) bq.delete();
    for (int i = 0; i < 4; i++) begin
      mm[32'h200 + 32'(4*i)]  = pat(32'h200 + 32'(4*i));
      mm[32'h500 + 32'(4*i)]  = pat(32'h500 + 32'(4*i));
      mm[32'h900 + 32'(4*i)]  = pat(32'h900 + 32'(4*i));
      mm[32'hD00 + 32'(4*i)]  = pat(32'hD00 + 32'(4*i));
      mm[32'h1100 + 32'(4*i)] = pat(32'h1100 + 32'(4*i));
    end
    mm[32'h100] = 32'h11223344; mm[32'h104] = 32'h55667788;
    mm[32'h108] = 32'h99AABBCC; mm[32'h10C] = 32'hDDEEFF00;
    mm[32'h204] = 32'h8000_1234;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hit",   32'(hit),         32'd0);
    chk("rst_stall", 32'(stall),       32'd0);
    chk("rst_req",   32'(mif.mem_req), 32'd0);
    chk("rst_we",    32'(mif.mem_we),  32'd0);
    chk("rst_rdata", ReadData_c,       32'd0);
    @(posedge clk); #1; rst_n = 1;

    // Cold miss, then sub-word access on the resident line
    exp_read(32'h100);
    access("cold_lw", 1, 0, 32'h100, 0, F3_W, 32'h11223344, 9);
    @(negedge clk);
    chk("idle_hit",   32'(hit),   32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    access("sb",      0, 1, 32'h101, 32'h000000AB, F3_B, 0, 0);
    access("lw_mrg",  1, 0, 32'h100, 0, F3_W,  32'h1122AB44, 0);
    access("lb",      1, 0, 32'h101, 0, F3_B,  32'hFFFFFFAB, 0);
    access("lbu",     1, 0, 32'h101, 0, F3_BU, 32'h000000AB, 0);
    access("lb3",     1, 0, 32'h103, 0, F3_B,  32'h00000011, 0);
    exp_read(32'h200);
    access("lh",      1, 0, 32'h206, 0, F3_H,  32'hFFFF8000, 9);
    access("lhu",     1, 0, 32'h206, 0, F3_HU, 32'h00008000, 0);
    access("lh_lo",   1, 0, 32'h204, 0, F3_H,  32'h00001234, 0);
    access("sh_both", 1, 1, 32'h20A, 32'h0000BEEF, F3_H, 0, 0);
    access("lw_sh",   1, 0, 32'h208, 0, F3_W,  32'hBEEF0208, 0);
    access("sw_f3_3", 0, 1, 32'h20E, 32'hDEADBEEF, 3'b011, 0, 0);
    access("lw_f3_3", 1, 0, 32'h20C, 0, F3_W,  32'hDEADBEEF, 0);

    // Reset drops dirty lines; LRU eviction set at index 0x10
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    exp_read(32'h100);
    access("ev_100",  1, 0, 32'h100, 0, F3_W, 32'h11223344, 9);
    exp_read(32'h500);
    access("ev_500",  1, 0, 32'h500, 0, F3_W, pat(32'h500), 9);
    access("ev_sw",   0, 1, 32'h500, 32'hCAFEF00D, F3_W, 0, 0);
    exp_read(32'h900);
    access("ev_900",  1, 0, 32'h900, 0, F3_W, pat(32'h900), 9);
    exp_write(32'h500, 32'hCAFEF00D, pat(32'h504), pat(32'h508), pat(32'h50C));
    exp_read(32'h100);
    access("ev_dirty", 1, 0, 32'h100, 0, F3_W, 32'h11223344, 17);

    // Slow memory: every beat waits three cycles for ack
    ack_delay = 3;
    access("sl_sw",   0, 1, 32'h100, 32'h0BADBEEF, F3_W, 0, 0);
    access("sl_900",  1, 0, 32'h900, 0, F3_W, pat(32'h900), 0);
    exp_write(32'h100, 32'h0BADBEEF, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
    exp_read(32'hD00);
    access("sl_d00",  1, 0, 32'hD00, 0, F3_W, pat(32'hD00), 33);
    ack_delay = 1;

    // Reset during refill beat 2
    exp_read(32'h1100);
    @(posedge clk); #1;
    rd_en = 1; wr_en = 0; addr = 32'h1100; funct3 = F3_W;
    start = acks; n = 0;
    while (acks < start + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mr_two_beats", 32'(acks - start), 32'd2);
    @(posedge clk); #1;
    rst_n = 0; rd_en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_req",   32'(mif.mem_req), 32'd0);
    chk("mr_stall", 32'(stall),       32'd0);
    bq.delete();
    @(posedge clk); #1; rst_n = 1;
    exp_read(32'h100);
    access("mr_reload", 1, 0, 32'h100, 0, F3_W, 32'h0BADBEEF, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
